mac_acumulador: RTL and testbench

- Sequential signed multiply-accumulate stage that feeds the 18-bit fixed-point rescaler.
- Consumes a stream of 18-bit signed operand pairs and accumulates N_TERMS products into a 60-bit two's-complement sum.
- Presents the sum as r[59:0], together with the scaling selector s[5:0] captured with the first term of the block, under a valid/ready handshake.

---
 rtl/mac_acumulador.sv | 98 +++++++++
 tb/tb_mac_acumulador.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acumulador.sv
// Signed multiply-accumulate stage: sums N_TERMS products of DW-bit operand pairs
// into an AW-bit result, tagged with the scaling selector of the block's first term.
module mac_acumulador #(
  parameter int DW      = 18,
  parameter int AW      = 60,
  parameter int N_TERMS = 16,
  parameter int CW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  input  logic [5:0]           s_cfg,
  output logic signed [AW-1:0] r,
  output logic [5:0]           s,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [CW-1:0] LAST_IDX = CW'(N_TERMS - 1);

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  // Valid never depends on ready; r/s are held while out_valid=1 and out_ready=0.
  // The whole pipeline advances only when the output register can take a result.
  logic en;
  logic xfer_in;
  logic xfer_out;

  logic [CW-1:0]          count;
  logic signed [2*DW-1:0] p;
  logic                   p_v;
  logic                   p_first;
  logic                   p_last;
  logic [5:0]             s_hold;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   p_ext;
  logic signed [AW-1:0]   acc_next;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !clr;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  assign p_ext    = {{(AW-2*DW){p[2*DW-1]}}, p};
  assign acc_next = (p_first ? '0 : acc) + p_ext;

  // Stage 1: product register and term counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      p       <= '0;
      p_v     <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      s_hold  <= '0;
    end else if (clr) begin
      count <= '0;
      p_v   <= 1'b0;
    end else if (en) begin
      p       <= a * b;
      p_v     <= xfer_in;
      p_first <= (count == '0);
      p_last  <= (count == LAST_IDX);
      if (xfer_in) begin
        count <= (count == LAST_IDX) ? '0 : count + 1'b1;
        if (count == '0) s_hold <= s_cfg;
      end
    end
  end

  // Stage 2: accumulator and output register. s_hold is still the current block's
  // selector here, since the next block's first term overwrites it on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      r         <= '0;
      s         <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (en && p_v) begin
        acc <= acc_next;
        if (p_last) begin
          r <= acc_next;
          s <= s_hold;
        end
      end
      if (en && p_v && p_last) out_valid <= 1'b1;
      else if (xfer_out)       out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_acumulador.sv
// Self-checking bench for mac_acumulador: directed scenarios plus a randomized phase,
// all results checked against a block-sum reference model and scoreboard.
module tb_mac_acumulador;

  localparam int N = 16;

  logic               clk;
  logic               rst;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] a;
  logic signed [17:0] b;
  logic [5:0]         s_cfg;
  logic [59:0]        r;
  logic [5:0]         s;
  logic               out_valid;
  logic               out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int or_mode = 0;

  logic [59:0] exp_r_q[$];
  logic [5:0]  exp_s_q[$];
  int          m_cnt;
  longint      m_sum;
  logic [5:0]  m_s;

  mac_acumulador #(.DW(18), .AW(60), .N_TERMS(N), .CW(10)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s_cfg(s_cfg),
    .r(r), .s(s), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] f60(input longint v);
    return {4'b0, v[59:0]};
  endfunction

  // out_ready driver: 0 = hold low, 1 = hold high, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model + scoreboard: a block's result is the plain sum of the products
  // of its N accepted pairs, tagged with the selector offered with its first pair.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_sum = 0;
      exp_r_q.delete();
      exp_s_q.delete();
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'((!out_valid || out_ready) && !clr));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_r_q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          chk("sb_r", {4'b0, r}, {4'b0, exp_r_q.pop_front()});
          chk("sb_s", 64'(s), 64'(exp_s_q.pop_front()));
        end
      end
      if (clr) begin
        m_cnt = 0;
        m_sum = 0;
        exp_r_q.delete();
        exp_s_q.delete();
      end else if (in_valid && in_ready) begin
        if (m_cnt == 0) m_s = s_cfg;
        m_sum += longint'(a) * longint'(b);
        m_cnt++;
        if (m_cnt == N) begin
          exp_r_q.push_back(m_sum[59:0]);
          exp_s_q.push_back(m_s);
          m_cnt = 0;
          m_sum = 0;
        end
      end
    end
  end

  // driver tasks: inputs change only at posedge+1
  task automatic send(input logic signed [17:0] ta, input logic signed [17:0] tb_v,
                      input logic [5:0] ts);
    int n;
    a = ta;
    b = tb_v;
    s_cfg = ts;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [59:0] rr, output logic [5:0] ss);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out", 64'(out_valid), 64'(1));
    rr = r;
    ss = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_r_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_r_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [59:0] rr, r0;
    logic [5:0]  ss, s0;
    int          n0;
    longint      ev;

    rst = 1'b1;
    clr = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    s_cfg = '0;
    or_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_r", {4'b0, r}, 64'(0));
    chk("rst_s", 64'(s), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    or_mode = 1;
    @(posedge clk);
    #1;

    // basic block, latency and single pulse
    n0 = n_out;
    for (int i = 0; i < N; i++) send(18'sd3, -18'sd5, (i == 0) ? 6'd4 : 6'($urandom_range(0, 63)));
    idle();
    @(negedge clk);
    chk("lat_early", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("basic_r", {4'b0, r}, {4'b0, 60'hFFFFFFFFFFFFF10});
    chk("basic_s", 64'(s), 64'(4));
    repeat (5) @(negedge clk);
    chk("pulse_count", 64'(n_out - n0), 64'(1));
    @(posedge clk);
    #1;

    // operand extremes
    for (int i = 0; i < N; i++) send(-18'sd131072, -18'sd131072, 6'd1);
    idle();
    wait_out(rr, ss);
    chk("ext_pos_r", {4'b0, rr}, f60(longint'(1) << 38));
    for (int i = 0; i < N; i++) send(-18'sd131072, 18'sd131071, 6'd2);
    idle();
    wait_out(rr, ss);
    ev = -64'sd16 * 64'sd17179738112;
    chk("ext_neg_r", {4'b0, rr}, f60(ev));
    chk("ext_neg_s", 64'(ss), 64'(2));

    // back-pressure: result held, input stalled
    or_mode = 0;
    for (int i = 0; i < N; i++) send(18'sd7, -18'sd9, (i == 0) ? 6'd12 : 6'd0);
    idle();
    wait_out(r0, s0);
    chk("bp_r", {4'b0, r0}, f60(-1008));
    chk("bp_s", 64'(s0), 64'(12));
    a = 18'sd1;
    b = 18'sd1;
    s_cfg = 6'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_r_stable", {4'b0, r}, {4'b0, r0});
      chk("bp_s_stable", 64'(s), 64'(s0));
    end
    @(posedge clk);
    #1;
    or_mode = 1;
    for (int i = 0; i < N; i++) send(18'sd1, 18'sd1, (i == 0) ? 6'd9 : 6'($urandom_range(0, 63)));
    idle();
    wait_out(rr, ss);
    chk("bp_next_r", {4'b0, rr}, f60(16));
    chk("bp_next_s", 64'(ss), 64'(9));

    // back-to-back blocks with selector changing on non-first terms
    for (int i = 0; i < 2 * N; i++)
      send(18'(i + 1), 18'(3 - i), (i == 0) ? 6'd7 : (i == N) ? 6'd42 : 6'($urandom_range(0, 63)));
    idle();
    drain();

    // clr mid-block discards the partial sum and same-cycle input
    for (int i = 0; i < 5; i++) send(18'sd100, 18'sd100, 6'd5);
    a = 18'sd50;
    b = 18'sd50;
    clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    clr = 1'b0;
    idle();
    for (int i = 0; i < N; i++) send(18'sd2, 18'sd2, (i == 0) ? 6'd3 : 6'd0);
    idle();
    wait_out(rr, ss);
    chk("clr_r", {4'b0, rr}, f60(64));
    chk("clr_s", 64'(ss), 64'(3));
    drain();

    // async reset mid-block
    for (int i = 0; i < 7; i++) send(18'sd5, 18'sd5, 6'd8);
    idle();
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send(-18'sd3, 18'sd4, (i == 0) ? 6'd50 : 6'd1);
    idle();
    wait_out(rr, ss);
    chk("arst_r", {4'b0, rr}, f60(-192));
    chk("arst_s", 64'(ss), 64'(50));

    // async reset while a result is held
    or_mode = 0;
    for (int i = 0; i < N; i++) send(18'sd1, 18'sd2, 6'd6);
    idle();
    wait_out(rr, ss);
    #1 rst = 1'b1;
    #1;
    chk("arst_held_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    or_mode = 1;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_stale", 64'(out_valid), 64'(0));
    end
    @(posedge clk);
    #1;

    // randomized traffic with random gaps and back-pressure
    or_mode = 2;
    for (int k = 0; k < 20 * N; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
      send(18'($urandom), 18'($urandom), 6'($urandom_range(0, 63)));
    end
    idle();
    or_mode = 1;
    drain();
    chk("final_partial", 64'(m_cnt), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
